// File: rtl/psram_arb_defs_pkg.sv
// rtl/psram_arb_defs_pkg.sv - shared FSM encoding and default widths for the PSRAM access arbiter
package psram_arb_defs;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/host_wr_fifo.sv
// rtl/host_wr_fifo.sv - synchronous host write buffer with registered full flag
module host_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/psram_access_arbiter.sv
// rtl/psram_access_arbiter.sv - arbitrates the PSRAM user port between video reads and buffered host writes
module psram_access_arbiter
    import psram_arb_defs::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_vid_blank,
    input  logic              I_vid_req,
    input  logic [ADDR_W-1:0] I_vid_addr,
    output logic [DATA_W-1:0] O_vid_data,
    output logic              O_vid_valid,
    output logic              O_vid_drop,
    input  logic              I_host_wr,
    input  logic [ADDR_W-1:0] I_host_addr,
    input  logic [DATA_W-1:0] I_host_data,
    output logic              O_host_ready,
    output logic              O_ram_oe,
    output logic              O_ram_wr,
    output logic [ADDR_W-1:0] O_ram_addr,
    output logic [DATA_W-1:0] O_ram_din,
    input  logic [DATA_W-1:0] I_ram_dout,
    input  logic              I_ram_done,
    output logic              O_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_e         state_q;
    logic               pend_q;
    logic [ADDR_W-1:0]  pend_addr_q;
    logic [7:0]         tmo_q;
    logic               ram_oe_q;
    logic               ram_wr_q;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [DATA_W-1:0]  ram_din_q;
    logic [DATA_W-1:0]  vid_data_q;
    logic               vid_valid_q;
    logic               vid_drop_q;
    logic               err_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic                     rd_go;
    logic                     rd_direct;
    logic                     wr_go;
    logic [ADDR_W-1:0]        rd_addr;

    // A request arriving in an idle cycle with nothing pending is issued directly.
    assign rd_direct = (state_q == ST_IDLE) && !pend_q && I_vid_req;
    assign rd_go     = (state_q == ST_IDLE) && (pend_q || I_vid_req);
    assign wr_go     = (state_q == ST_IDLE) && !rd_go && I_vid_blank && !fifo_empty;
    assign rd_addr   = pend_q ? pend_addr_q : I_vid_addr;

    host_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i       (I_clk),
        .rst_n_i     (I_rst_n),
        .push_i      (I_host_wr),
        .push_data_i ({I_host_addr, I_host_data}),
        .pop_i       (wr_go),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            tmo_q       <= '0;
            ram_oe_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_drop_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vid_valid_q <= 1'b0;
            vid_drop_q  <= 1'b0;

            if (I_vid_req && !rd_direct) begin
                pend_q      <= 1'b1;
                pend_addr_q <= I_vid_addr;
                vid_drop_q  <= pend_q && !rd_go;
            end else if (rd_go) begin
                pend_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (rd_go) begin
                        state_q    <= ST_RD;
                        ram_oe_q   <= 1'b1;
                        ram_addr_q <= rd_addr;
                    end else if (wr_go) begin
                        state_q    <= ST_WR;
                        ram_wr_q   <= 1'b1;
                        ram_addr_q <= fifo_head[ADDR_W+DATA_W-1:DATA_W];
                        ram_din_q  <= fifo_head[DATA_W-1:0];
                    end
                end
                ST_RD, ST_WR: begin
                    if (I_ram_done) begin
                        if (state_q == ST_RD) begin
                            vid_data_q  <= I_ram_dout;
                            vid_valid_q <= 1'b1;
                        end
                        ram_oe_q <= 1'b0;
                        ram_wr_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        ram_oe_q <= 1'b0;
                        ram_wr_q <= 1'b0;
                        err_q    <= 1'b1;
                        tmo_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    ram_oe_q <= 1'b0;
                    ram_wr_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_vid_data   = vid_data_q;
    assign O_vid_valid  = vid_valid_q;
    assign O_vid_drop   = vid_drop_q;
    assign O_host_ready = !fifo_full;
    assign O_ram_oe     = ram_oe_q;
    assign O_ram_wr     = ram_wr_q;
    assign O_ram_addr   = ram_addr_q;
    assign O_ram_din    = ram_din_q;
    assign O_err        = err_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// tb/tb_psram_access_arbiter.sv - directed self-checking bench for psram_access_arbiter
module tb_psram_access_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_blank = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_drop;
    logic          host_wr = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_ready;
    logic          ram_oe;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = 16'hBEEF;
    logic          ram_done = 1'b0;
    logic          err;

    int total = 0;
    int bad   = 0;

    int  cyc = 0;
    logic busy = 1'b0;
    int  cnt = 0;
    logic hold_done = 1'b0;
    int  n_valid = 0;
    int  n_drop = 0;
    logic [DW-1:0] last_valid = '0;

    int            log_cyc[$];
    logic          log_wr[$];
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_din[$];

    psram_access_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_vid_blank  (vid_blank),
        .I_vid_req    (vid_req),
        .I_vid_addr   (vid_addr),
        .O_vid_data   (vid_data),
        .O_vid_valid  (vid_valid),
        .O_vid_drop   (vid_drop),
        .I_host_wr    (host_wr),
        .I_host_addr  (host_addr),
        .I_host_data  (host_data),
        .O_host_ready (host_ready),
        .O_ram_oe     (ram_oe),
        .O_ram_wr     (ram_wr),
        .O_ram_addr   (ram_addr),
        .O_ram_din    (ram_din),
        .I_ram_dout   (ram_dout),
        .I_ram_done   (ram_done),
        .O_err        (err)
    );

    always #5 clk = ~clk;

    // Wrapper model: done is sampled LAT edges after the command is first sampled.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (vid_valid) begin
            n_valid++;
            last_valid = vid_data;
        end
        if (vid_drop) n_drop++;
        if (ram_done) begin
            ram_done = 1'b0;
            busy     = 1'b0;
        end else if (busy) begin
            if (!(ram_oe || ram_wr)) begin
                busy = 1'b0;
            end else begin
                cnt++;
                if (cnt == LAT + 1 && !hold_done) ram_done = 1'b1;
            end
        end else if (ram_oe || ram_wr) begin
            busy = 1'b1;
            cnt  = 1;
            log_cyc.push_back(cyc);
            log_wr.push_back(ram_wr);
            log_addr.push_back(ram_addr);
            log_din.push_back(ram_din);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_wr.delete();
        log_addr.delete();
        log_din.delete();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_wr   = 1'b1;
        host_addr = a;
        host_data = d;
        @(negedge clk);
        host_wr   = 1'b0;
    endtask

    initial begin
        int nv0;
        int nd0;
        int oe_cnt;
        int waited;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_oe", ram_oe, 0);
        check("rst_wr", ram_wr, 0);
        check("rst_valid", vid_valid, 0);
        check("rst_drop", vid_drop, 0);
        check("rst_err", err, 0);
        check("rst_ready", host_ready, 1);
        check("rst_addr", ram_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single read, done latency 3
        clear_log();
        vid_req  = 1'b1;
        vid_addr = 22'h000010;
        @(negedge clk);
        vid_req = 1'b0;
        check("rd_oe_t1", ram_oe, 1);
        check("rd_addr_t1", ram_addr, 32'h10);
        repeat (3) @(negedge clk);
        check("rd_valid_t4", vid_valid, 0);
        @(negedge clk);
        check("rd_valid_t5", vid_valid, 1);
        check("rd_data_t5", vid_data, 32'hBEEF);
        @(negedge clk);
        check("rd_valid_pulse", vid_valid, 0);
        check("rd_oe_dropped", ram_oe, 0);
        repeat (3) @(negedge clk);

        // writes held off during active video, then drained in order
        clear_log();
        push(22'h1, 16'h1111);
        push(22'h2, 16'h2222);
        push(22'h3, 16'h3333);
        repeat (5) @(negedge clk);
        check("noblank_nowr", log_addr.size(), 0);
        check("noblank_wr", ram_wr, 0);
        vid_blank = 1'b1;
        repeat (30) @(negedge clk);
        vid_blank = 1'b0;
        check("drain3_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("drain3_iswr%0d", i), log_wr[i], 1);
                check($sformatf("drain3_addr%0d", i), log_addr[i], i + 1);
                check($sformatf("drain3_din%0d", i), log_din[i], (i + 1) * 32'h1111);
            end
            check("drain3_gap01", (log_cyc[1] - log_cyc[0]) >= 2, 1);
            check("drain3_gap12", (log_cyc[2] - log_cyc[1]) >= 2, 1);
        end

        // fill the FIFO, fifth push ignored
        clear_log();
        push(22'h11, 16'h0011);
        push(22'h12, 16'h0012);
        push(22'h13, 16'h0013);
        check("ready_after3", host_ready, 1);
        push(22'h14, 16'h0014);
        check("ready_after4", host_ready, 0);
        push(22'h15, 16'h0015);
        check("ready_after5", host_ready, 0);
        vid_blank = 1'b1;
        repeat (40) @(negedge clk);
        vid_blank = 1'b0;
        check("drain4_count", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drain4_addr%0d", i), log_addr[i], 32'h11 + i);
            end
        end
        check("ready_drained", host_ready, 1);

        // read arriving while a write is in flight goes before the next write
        clear_log();
        push(22'h21, 16'hA1A1);
        push(22'h22, 16'hA2A2);
        vid_blank = 1'b1;
        waited = 0;
        while (log_addr.size() == 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("mix_wr_started", log_addr.size(), 1);
        vid_req  = 1'b1;
        vid_addr = 22'h30;
        @(negedge clk);
        vid_req = 1'b0;
        repeat (40) @(negedge clk);
        vid_blank = 1'b0;
        check("mix_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            check("mix0_wr", {log_wr[0], 10'h0, log_addr[0]}, {1'b1, 10'h0, 22'h21});
            check("mix1_rd", {log_wr[1], 10'h0, log_addr[1]}, {1'b0, 10'h0, 22'h30});
            check("mix2_wr", {log_wr[2], 10'h0, log_addr[2]}, {1'b1, 10'h0, 22'h22});
        end

        // two requests while a read is in flight: one drop, newest served
        clear_log();
        nd0      = n_drop;
        vid_req  = 1'b1;
        vid_addr = 22'h40;
        @(negedge clk);
        vid_addr = 22'hA;
        @(negedge clk);
        vid_addr = 22'hB;
        @(negedge clk);
        vid_req = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_once", n_drop - nd0, 1);
        check("drop_rd_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("drop_rd0", log_addr[0], 32'h40);
            check("drop_rd1", log_addr[1], 32'hB);
            check("drop_rd1_isrd", log_wr[1], 0);
        end

        // timeout: done withheld, command held for 8 cycles
        hold_done = 1'b1;
        nv0       = n_valid;
        oe_cnt    = 0;
        vid_req   = 1'b1;
        vid_addr  = 22'h50;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vid_req = 1'b0;
            if (ram_oe) oe_cnt++;
        end
        check("tmo_oe_cycles", oe_cnt, 8);
        check("tmo_err", err, 1);
        check("tmo_no_valid", n_valid - nv0, 0);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", err, 1);
        hold_done = 1'b0;

        // reset in the middle of a read
        nv0      = n_valid;
        vid_req  = 1'b1;
        vid_addr = 22'h60;
        @(negedge clk);
        vid_req = 1'b0;
        check("mid_oe", ram_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_oe", ram_oe, 0);
        check("mid_rst_wr", ram_wr, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_ready", host_ready, 1);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_vdata", vid_data, 0);
        repeat (10) @(negedge clk);
        check("mid_rst_no_valid", n_valid - nv0, 0);
        check("mid_rst_idle", ram_oe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
